// File: rtl/fir_pkg.sv
// Shared constants, FSM states and write-window bounds for the FIR tap sequencer.
// Pure definitions, no logic.
package fir_pkg;
   localparam int DIV    = 40;
   localparam int TAPS   = 10;
   localparam int WIN_LO = 23;
   localparam int WIN_HI = 38;

   typedef enum logic [2:0] {IDLE, STROBE, FETCH, MAC, ACC, DONE} state_t;

   function automatic logic fnInWindow(input int c);
      return (c >= WIN_LO) && (c <= WIN_HI);
   endfunction
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Host, coefficient-memory and MAC-datapath signals of the tap sequencer.
// master = host/datapath side, slave = sequencer.
interface fir_tap_sequencer_if;
   logic       iEnable;
   logic       iCoefWrReq;
   logic [3:0] iCoefWrAddr;
   logic       oCoefWrAck;
   logic       oCoefWe;
   logic       oCoefRd;
   logic [3:0] oCoefAddr;
   logic       oEnSample_300k;
   logic [3:0] oEnMul;
   logic       oEnAdd;
   logic       oEnAcc;
   logic       oOutValid;
   logic       oBusy;

   modport master (
      output iEnable, iCoefWrReq, iCoefWrAddr,
      input  oCoefWrAck, oCoefWe, oCoefRd, oCoefAddr, oEnSample_300k,
             oEnMul, oEnAdd, oEnAcc, oOutValid, oBusy
   );

   modport slave (
      input  iEnable, iCoefWrReq, iCoefWrAddr,
      output oCoefWrAck, oCoefWe, oCoefRd, oCoefAddr, oEnSample_300k,
             oEnMul, oEnAdd, oEnAcc, oOutValid, oBusy
   );
endinterface

// File: rtl/fir_frame_counter.sv
// Sample-frame position counter 0..DIV-1; holds 0 while stopped, restarts at 0 on iStart.
// iStop forces stopped with count 0 on the same edge.
module fir_frame_counter #(
   parameter int DIV = fir_pkg::DIV
) (
   input  logic                     iClk_12M,
   input  logic                     iRst,
   input  logic                     iStart,
   input  logic                     iStop,
   output logic [$clog2(DIV)-1:0]   oCnt,
   output logic                     oRunning
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         oCnt     <= '0;
         oRunning <= 1'b0;
      end else if (!oRunning) begin
         // The start cycle itself is frame position 0.
         oCnt     <= '0;
         oRunning <= iStart;
      end else if (iStop) begin
         oCnt     <= '0;
         oRunning <= 1'b0;
      end else if (oCnt == LAST) begin
         oCnt <= '0;
      end else begin
         oCnt <= oCnt + 1'b1;
      end
   end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Per-frame strobe/fetch/MAC/accumulate sequencer with host coefficient-write arbitration.
// All outputs registered; host writes wait (level request) until an idle window cycle.
module fir_tap_sequencer #(
   parameter int DIV  = fir_pkg::DIV,
   parameter int TAPS = fir_pkg::TAPS
) (
   input  logic                   iClk_12M,
   input  logic                   iRst,
   fir_tap_sequencer_if.slave     bus
);
   import fir_pkg::*;

   localparam int CW = $clog2(DIV);

   state_t        state;
   logic [3:0]    tap;
   logic          armed;
   logic [CW-1:0] cnt;
   logic          running;
   logic          lastCnt;
   logic          frameStart;
   logic          stopNow;
   logic          nextIdle;
   logic          nextStopped;
   logic          wrGrant;
   int            cntNext;

   fir_frame_counter #(.DIV(DIV)) uCounter (
      .iClk_12M (iClk_12M),
      .iRst     (iRst),
      .iStart   (frameStart),
      .iStop    (stopNow),
      .oCnt     (cnt),
      .oRunning (running)
   );

   assign lastCnt = (cnt == CW'(DIV - 1));

   always_comb begin
      frameStart  = (state == IDLE) && bus.iEnable && (!running || lastCnt);
      stopNow     = running && !bus.iEnable &&
                    ((state == DONE) || ((state == IDLE) && lastCnt));
      nextIdle    = ((state == IDLE) && !frameStart) || (state == DONE);
      nextStopped = stopNow || (!running && !frameStart);
      cntNext     = (running && !stopNow && !lastCnt) ? int'(cnt) + 1 : 0;
      // Window is judged on the cycle the grant will be visible in.
      wrGrant     = nextIdle && (nextStopped || fnInWindow(cntNext)) && armed &&
                    bus.iCoefWrReq && (int'(bus.iCoefWrAddr) < TAPS);
   end

   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         state              <= IDLE;
         tap                <= '0;
         armed              <= 1'b0;
         bus.oEnSample_300k <= 1'b0;
         bus.oEnMul         <= '0;
         bus.oEnAdd         <= 1'b0;
         bus.oEnAcc         <= 1'b0;
         bus.oOutValid      <= 1'b0;
         bus.oBusy          <= 1'b0;
         bus.oCoefRd        <= 1'b0;
         bus.oCoefWe        <= 1'b0;
         bus.oCoefAddr      <= '0;
         bus.oCoefWrAck     <= 1'b0;
      end else begin
         bus.oEnSample_300k <= 1'b0;
         bus.oEnMul         <= '0;
         bus.oEnAdd         <= 1'b0;
         bus.oEnAcc         <= 1'b0;
         bus.oOutValid      <= 1'b0;
         bus.oCoefRd        <= 1'b0;
         bus.oCoefWe        <= 1'b0;
         bus.oCoefWrAck     <= 1'b0;
         bus.oBusy          <= !nextIdle;

         // A held request must be seen low before it can be granted again.
         if (wrGrant)
            armed <= 1'b0;
         else if (!bus.iCoefWrReq)
            armed <= 1'b1;

         if (wrGrant) begin
            bus.oCoefWe    <= 1'b1;
            bus.oCoefWrAck <= 1'b1;
            bus.oCoefAddr  <= bus.iCoefWrAddr;
         end

         unique case (state)
            IDLE: begin
               if (frameStart) begin
                  state              <= STROBE;
                  bus.oEnSample_300k <= 1'b1;
               end
            end
            STROBE: begin
               state         <= FETCH;
               tap           <= '0;
               bus.oCoefRd   <= 1'b1;
               bus.oCoefAddr <= '0;
            end
            FETCH: begin
               state      <= MAC;
               bus.oEnMul <= tap + 4'd1;
               bus.oEnAdd <= 1'b1;
            end
            MAC: begin
               if (int'(tap) == TAPS - 1) begin
                  state      <= ACC;
                  bus.oEnAcc <= 1'b1;
               end else begin
                  state         <= FETCH;
                  tap           <= tap + 4'd1;
                  bus.oCoefRd   <= 1'b1;
                  bus.oCoefAddr <= tap + 4'd1;
               end
            end
            ACC: begin
               state         <= DONE;
               bus.oOutValid <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench: stimulus queues the expected activity per cycle, a negedge monitor
// pops one record for every cycle the DUT shows any activity.
module tb_fir_tap_sequencer;
   logic iClk_12M = 1'b0;
   logic iRst;

   fir_tap_sequencer_if bus();

   fir_tap_sequencer #(.DIV(40), .TAPS(10)) dut (
      .iClk_12M (iClk_12M),
      .iRst     (iRst),
      .bus      (bus)
   );

   always #5 iClk_12M = ~iClk_12M;

   typedef struct {
      int         cyc;
      logic       smp;
      logic [3:0] mul;
      logic       add;
      logic       acc;
      logic       vld;
      logic       rd;
      logic       we;
      logic       ack;
      logic       busy;
      logic [3:0] addr;
   } exp_t;

   exp_t expQ[$];
   exp_t mExp;
   logic mAny;
   int   nCmp = 0;
   int   nBad = 0;
   int   cyc  = 0;
   int   B;
   int   badAcks;

   always @(posedge iClk_12M) cyc <= cyc + 1;

   function automatic exp_t blank(input int c);
      exp_t r;
      r.cyc = c; r.smp = 0; r.mul = 0; r.add = 0; r.acc = 0; r.vld = 0;
      r.rd = 0; r.we = 0; r.ack = 0; r.busy = 0; r.addr = 0;
      return r;
   endfunction

   // Frame offsets: 0 strobe, odd 1..19 fetch tap (o-1)/2, even 2..20 MAC tap o/2, 21 acc, 22 valid.
   task automatic pushFrame(input int base, input int lastOff);
      for (int o = 0; o <= lastOff; o++) begin
         exp_t r;
         r = blank(base + o);
         r.busy = 1;
         if (o == 0) r.smp = 1;
         else if (o <= 20 && (o % 2) == 1) begin r.rd = 1; r.addr = 4'((o - 1) / 2); end
         else if (o <= 20) begin r.mul = 4'(o / 2); r.add = 1; end
         else if (o == 21) r.acc = 1;
         else r.vld = 1;
         expQ.push_back(r);
      end
   endtask

   task automatic pushGrant(input int c, input logic [3:0] a);
      exp_t r;
      r = blank(c);
      r.we = 1; r.ack = 1; r.addr = a;
      expQ.push_back(r);
   endtask

   function automatic bit evMatch(input exp_t e);
      return (e.cyc == cyc) && (e.smp == bus.oEnSample_300k) && (e.mul == bus.oEnMul) &&
             (e.add == bus.oEnAdd) && (e.acc == bus.oEnAcc) && (e.vld == bus.oOutValid) &&
             (e.rd == bus.oCoefRd) && (e.we == bus.oCoefWe) && (e.ack == bus.oCoefWrAck) &&
             (e.busy == bus.oBusy) && (!(e.rd || e.we) || (e.addr == bus.oCoefAddr));
   endfunction

   always @(negedge iClk_12M) begin
      mAny = bus.oEnSample_300k | (bus.oEnMul != 4'd0) | bus.oEnAdd | bus.oEnAcc | bus.oOutValid |
             bus.oCoefRd | bus.oCoefWe | bus.oCoefWrAck | bus.oBusy;
      if (mAny) begin
         nCmp++;
         if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL unexpected_event cyc=%0d: got smp=%b mul=%0d add=%b acc=%b vld=%b rd=%b we=%b ack=%b busy=%b addr=%0d, required no activity",
                     cyc, bus.oEnSample_300k, bus.oEnMul, bus.oEnAdd, bus.oEnAcc, bus.oOutValid,
                     bus.oCoefRd, bus.oCoefWe, bus.oCoefWrAck, bus.oBusy, bus.oCoefAddr);
         end else begin
            mExp = expQ.pop_front();
            if (!evMatch(mExp)) begin
               nBad++;
               $display("FAIL event cyc=%0d: got smp=%b mul=%0d add=%b acc=%b vld=%b rd=%b we=%b ack=%b busy=%b addr=%0d, required cyc=%0d smp=%b mul=%0d add=%b acc=%b vld=%b rd=%b we=%b ack=%b busy=%b addr=%0d",
                        cyc, bus.oEnSample_300k, bus.oEnMul, bus.oEnAdd, bus.oEnAcc, bus.oOutValid,
                        bus.oCoefRd, bus.oCoefWe, bus.oCoefWrAck, bus.oBusy, bus.oCoefAddr,
                        mExp.cyc, mExp.smp, mExp.mul, mExp.add, mExp.acc, mExp.vld,
                        mExp.rd, mExp.we, mExp.ack, mExp.busy, mExp.addr);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      nCmp++;
      if (act != req) begin
         nBad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge iClk_12M);
      #1;
   endtask

   task automatic waitCyc(input int n);
      while (cyc < n) step();
   endtask

   // Host: hold request until ack, drop it for one cycle, return.
   task automatic hostWrite(input logic [3:0] a, input int budget);
      bit got;
      got = 0;
      bus.iCoefWrAddr = a;
      bus.iCoefWrReq  = 1'b1;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         if (bus.oCoefWrAck) got = 1;
      end
      bus.iCoefWrReq = 1'b0;
      nCmp++;
      if (!got) begin
         nBad++;
         $display("FAIL write_ack_timeout addr=%0d: got no ack in %0d cycles, required one ack", a, budget);
      end
      step();
   endtask

   initial begin
      iRst            = 1'b1;
      bus.iEnable     = 1'b1;
      bus.iCoefWrReq  = 1'b0;
      bus.iCoefWrAddr = 4'd0;
      repeat (3) step();

      chk("rst_oEnSample_300k", int'(bus.oEnSample_300k), 0);
      chk("rst_oEnMul",         int'(bus.oEnMul),         0);
      chk("rst_oEnAdd",         int'(bus.oEnAdd),         0);
      chk("rst_oEnAcc",         int'(bus.oEnAcc),         0);
      chk("rst_oOutValid",      int'(bus.oOutValid),      0);
      chk("rst_oBusy",          int'(bus.oBusy),          0);
      chk("rst_oCoefRd",        int'(bus.oCoefRd),        0);
      chk("rst_oCoefWe",        int'(bus.oCoefWe),        0);
      chk("rst_oCoefAddr",      int'(bus.oCoefAddr),      0);
      chk("rst_oCoefWrAck",     int'(bus.oCoefWrAck),     0);

      // Frame 0 starts on the first cycle after release.
      B = cyc + 1;
      pushFrame(B, 22);
      pushGrant(B + 23, 4'd3);
      pushGrant(B + 38, 4'd5);
      pushFrame(B + 40, 22);
      iRst = 1'b0;

      // Request at c=5 waits for the window at c=23.
      waitCyc(B + 5);
      hostWrite(4'd3, 40);

      // Request held across 38..2: single ack at c=38, strobe at 40 untouched.
      waitCyc(B + 37);
      bus.iCoefWrAddr = 4'd5;
      bus.iCoefWrReq  = 1'b1;
      waitCyc(B + 42);
      bus.iCoefWrReq  = 1'b0;

      pushFrame(B + 80, 22);
      pushGrant(B + 106, 4'd7);
      pushGrant(B + 108, 4'd9);
      pushFrame(B + 131, 15);
      pushFrame(B + 148, 22);
      pushFrame(B + 188, 22);
      pushFrame(B + 228, 22);
      pushFrame(B + 268, 22);

      // Enable dropped at c=10: frame completes, then stopped; writes every other cycle.
      waitCyc(B + 90);
      bus.iEnable = 1'b0;
      waitCyc(B + 105);
      hostWrite(4'd7, 10);
      hostWrite(4'd9, 10);
      waitCyc(B + 130);
      bus.iEnable = 1'b1;

      // Reset at c=15 of the restarted frame.
      waitCyc(B + 146);
      iRst = 1'b1;
      step();
      chk("midrst_oCoefAddr", int'(bus.oCoefAddr), 0);
      chk("midrst_oBusy",     int'(bus.oBusy),     0);
      chk("midrst_oOutValid", int'(bus.oOutValid), 0);
      iRst = 1'b0;

      // Out-of-range tap index held for 100 cycles.
      waitCyc(B + 150);
      bus.iCoefWrAddr = 4'd12;
      bus.iCoefWrReq  = 1'b1;
      badAcks = 0;
      repeat (100) begin
         step();
         if (bus.oCoefWrAck || bus.oCoefWe) badAcks++;
      end
      chk("bad_addr_acks", badAcks, 0);
      bus.iCoefWrReq = 1'b0;

      waitCyc(B + 275);
      bus.iEnable = 1'b0;
      waitCyc(B + 320);

      nCmp++;
      if (expQ.size() != 0) begin
         nBad++;
         $display("FAIL missing_events: got %0d expected events never seen (first cyc=%0d), required 0",
                  expQ.size(), expQ[0].cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameters: DIV 40, clocks per sample frame (12 MHz / 300 kHz); TAPS 10, filter taps sequenced per frame.
REQ-002 SHALL have ports: iClk_12M  in  1  system clock, the only clock.
REQ-003 SHALL have ports: iRst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: iEnable  in  1  run request; frames start only while high.
REQ-005 SHALL have ports: iCoefWrReq  in  1  host coefficient write request, level, held until ack.
REQ-006 SHALL have ports: iCoefWrAddr  in  4  host tap index, 0..9.
REQ-007 SHALL have ports: oCoefWrAck  out  1  one-cycle pulse, write performed.
REQ-008 SHALL have ports: oCoefWe  out  1  coefficient memory write strobe.
REQ-009 SHALL have ports: oCoefRd  out  1  coefficient memory read strobe; read data valid next cycle.
REQ-010 SHALL have ports: oCoefAddr  out  4  coefficient memory address.
REQ-011 SHALL have ports: oEnSample_300k  out  1  one-cycle sample strobe to MAC datapath.
REQ-012 SHALL have ports: oEnMul  out  4  active tap number 1..10; 0 = no tap.
REQ-013 SHALL have ports: oEnAdd  out  1  shift/add enable for the active tap.
REQ-014 SHALL have ports: oEnAcc  out  1  one-cycle output accumulate/latch enable.
REQ-015 SHALL have ports: oOutValid  out  1  one-cycle pulse, oMac of the datapath valid.
REQ-016 SHALL have ports: oBusy  out  1  high while state is not IDLE.

Function
REQ-017 SHALL keep a frame counter c, 0..DIV-1, incrementing every cycle while running, wrapping 39->0.
REQ-018 SHALL use FSM states IDLE, STROBE, FETCH, MAC, ACC, DONE.
REQ-019 SHALL, at c=0 with iEnable=1, enter STROBE and assert oEnSample_300k for exactly that cycle.
REQ-020 SHALL, for tap k=0..9, spend cycle 1+2k in FETCH with oCoefRd=1 and oCoefAddr=k.
REQ-021 SHALL spend cycle 2+2k in MAC with oEnMul=k+1 and oEnAdd=1.
REQ-022 SHALL, after the last MAC at c=20, enter ACC at c=21 with oEnAcc=1, then DONE at c=22 with oOutValid=1, then IDLE.
REQ-023 SHALL hold oEnMul=0 and oEnAdd=0 outside MAC, and hold oCoefAddr at its last value while no read or write is active.
REQ-024 SHALL grant host writes only in IDLE with c in 23..38; grant cycle: oCoefWe=1, oCoefAddr=iCoefWrAddr, oCoefWrAck=1.
REQ-025 SHALL grant at most one write per two cycles; a request held continuously is acked once, then re-granted only after having been sampled low.
REQ-026 SHALL hold a request arriving outside the write window pending, without ack, until the next window; the sample frame always has priority.
REQ-027 SHALL ignore, without ack and without write, a request with iCoefWrAddr >= TAPS.
REQ-028 SHALL, if iEnable falls mid-frame, complete the current frame through DONE, then stop with c=0 in IDLE.
REQ-029 SHALL, while stopped, start the next frame on the first cycle iEnable is sampled high, treating that cycle as c=0.
REQ-030 SHALL keep granting host writes every other cycle while stopped.

Reset
REQ-031 SHALL, while iRst=1 at a clock edge, go to IDLE, stopped, with c=0.
REQ-032 SHALL drive every output to 0 during reset: oEnSample_300k, oEnMul, oEnAdd, oEnAcc, oOutValid, oBusy, oCoefRd, oCoefWe, oCoefAddr, oCoefWrAck.
REQ-033 SHALL abort any frame in progress on reset mid-frame, with no oOutValid, and discard any pending write.
REQ-034 SHALL, on the first cycle after reset release with iEnable=1, assert oEnSample_300k.

Structure
REQ-035 SHALL place DIV, TAPS, the state enumeration, and window bounds 23/38 in shared package fir_pkg.
REQ-036 SHALL use one sub-module, fir_frame_counter: counter with wrap, stop and restart.
REQ-037 SHALL put the FSM and write arbitration in the top-level block.

Verification
REQ-038 SHALL cover: reset release, iEnable=1 -> strobe at cycle 0; oEnMul 1..10 on cycles 2,4,..20; oEnAcc at 21; oOutValid at 22; next strobe at 40.
REQ-039 SHALL cover: iCoefWrReq raised at c=5, addr 3 -> single ack at c=23, oCoefWe=1, oCoefAddr=3; no overlap with FETCH.
REQ-040 SHALL cover: iCoefWrReq held at c=38 -> ack at c=38, none at c=39 or c=0; strobe unaffected.
REQ-041 SHALL cover: iEnable dropped at c=10 -> frame completes, oOutValid at 22, no strobe at 40; re-enable -> strobe on the same cycle.
REQ-042 SHALL cover: iRst pulsed at c=15 -> all outputs 0 next cycle, no oOutValid; strobe on the first cycle after release.
REQ-043 SHALL cover: write request with addr 12 -> no ack and no oCoefWe for 100 cycles.
